// File: rtl/uart_rx_param_module.sv
// Parametrised UART receiver: synchroniser, baud counter, 3-point majority
// sampling, false-start rejection, parity/frame/overrun reporting, and a
// held output word with a valid/ack handshake.
module uart_rx_param_module #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                 CLK,
    input  logic                 Rst,
    input  logic                 RX_En_Sig,
    input  logic                 RX_Pin_In,
    input  logic                 RX_Ack,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 RX_Done_Sig,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Overrun_Err,
    output logic                 Busy
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W    = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF     = CLKS_PER_BIT / 2;
    localparam bit          HAS_PAR  = (PARITY != 0);
    localparam bit          EVEN_PAR = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic                 sync1, sync2, sync_prev;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 s0, s0_n, s1, s1_n;
    logic                 perr_int, perr_n;
    logic                 ferr_int, ferr_n;
    logic                 deliver;
    logic [DATA_BITS-1:0] data_n;
    logic                 done_n, perr_o_n, ferr_o_n, ovr_n, busy_n;
    logic                 start_edge;
    logic                 vote;
    logic                 cnt_top;
    logic                 decide;

    // Line-derived and counter-derived helper terms
    assign start_edge = ~sync2 & sync_prev;
    assign vote       = (s0 & s1) | (s0 & sync2) | (s1 & sync2);
    assign cnt_top    = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign decide     = (cnt == CNT_W'(HALF + 1));

    // State, counters, datapath and output registers
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state       <= S_IDLE;
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            sync_prev   <= 1'b1;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            perr_int    <= 1'b0;
            ferr_int    <= 1'b0;
            RX_Data     <= '0;
            RX_Done_Sig <= 1'b0;
            Parity_Err  <= 1'b0;
            Frame_Err   <= 1'b0;
            Overrun_Err <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_n;
            sync1       <= RX_Pin_In;
            sync2       <= sync1;
            sync_prev   <= sync2;
            cnt         <= cnt_n;
            bit_cnt     <= bit_n;
            shift       <= shift_n;
            s0          <= s0_n;
            s1          <= s1_n;
            perr_int    <= perr_n;
            ferr_int    <= ferr_n;
            RX_Data     <= data_n;
            RX_Done_Sig <= done_n;
            Parity_Err  <= perr_o_n;
            Frame_Err   <= ferr_o_n;
            Overrun_Err <= ovr_n;
            Busy        <= busy_n;
        end
    end

    // Next-state, sampling, delivery and handshake logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt_top ? '0 : cnt + CNT_W'(1);
        bit_n    = bit_cnt;
        shift_n  = shift;
        s0_n     = (cnt == CNT_W'(HALF - 1)) ? sync2 : s0;
        s1_n     = (cnt == CNT_W'(HALF)) ? sync2 : s1;
        perr_n   = perr_int;
        ferr_n   = ferr_int;
        deliver  = 1'b0;
        data_n   = RX_Data;
        done_n   = RX_Done_Sig;
        perr_o_n = Parity_Err;
        ferr_o_n = Frame_Err;
        ovr_n    = Overrun_Err;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (start_edge && RX_En_Sig) begin
                    state_n = S_START;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                end
            end
            S_START: begin
                if (decide && vote) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (cnt_top) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_n = {vote, shift[DATA_BITS-1:1]};
                end
                if (cnt_top) begin
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        state_n = HAS_PAR ? S_PARITY : S_STOP;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    perr_n = EVEN_PAR ? ((^shift) != vote) : ((^shift) == vote);
                end
                if (cnt_top) begin
                    state_n = S_STOP;
                    bit_n   = '0;
                end
            end
            S_STOP: begin
                if (decide) begin
                    ferr_n = ferr_int | ~vote;
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        deliver = 1'b1;
                        state_n = S_IDLE;
                        cnt_n   = '0;
                        bit_n   = '0;
                    end
                end
                if (cnt_top) begin
                    bit_n = bit_cnt + BIT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                bit_n   = '0;
            end
        endcase

        // Disable aborts any frame in flight; delivered outputs are untouched
        if (!RX_En_Sig) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            bit_n   = '0;
            deliver = 1'b0;
        end

        // Delivery beats a coincident ack; otherwise ack clears the word
        if (deliver) begin
            if (!RX_Done_Sig || RX_Ack) begin
                data_n   = shift_n;
                done_n   = 1'b1;
                perr_o_n = perr_n;
                ferr_o_n = ferr_n;
                ovr_n    = 1'b0;
            end else begin
                ovr_n = 1'b1;
            end
        end else if (RX_Ack && RX_Done_Sig) begin
            done_n   = 1'b0;
            perr_o_n = 1'b0;
            ferr_o_n = 1'b0;
            ovr_n    = 1'b0;
        end

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_param_module.sv
// Scoreboard bench for uart_rx_param_module: four receivers with different
// frame formats share one clock; expected words are queued at send time and
// a negedge monitor compares every delivery.
`timescale 1ns/1ps
module tb_uart_rx_param_module;

    localparam int NI  = 4;
    localparam int CPB = 16;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         mid;
    } exp_t;

    logic          CLK = 1'b0;
    logic          Rst;
    logic [NI-1:0] pin, ack, en;
    logic [NI-1:0] done, perr, ferr, ovr, busy;
    logic [7:0]    d0, d2;
    logic [8:0]    d1;
    logic [4:0]    d3;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q [NI][$];

    logic [8:0] m_data [NI];
    logic       m_done [NI];
    logic       m_perr [NI];
    logic       m_ferr [NI];
    logic       m_ovr  [NI];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    uart_rx_param_module #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u0 (
        .CLK(CLK), .Rst(Rst), .RX_En_Sig(en[0]), .RX_Pin_In(pin[0]), .RX_Ack(ack[0]),
        .RX_Data(d0), .RX_Done_Sig(done[0]), .Parity_Err(perr[0]), .Frame_Err(ferr[0]),
        .Overrun_Err(ovr[0]), .Busy(busy[0]));
    uart_rx_param_module #(.DATA_BITS(9), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u1 (
        .CLK(CLK), .Rst(Rst), .RX_En_Sig(en[1]), .RX_Pin_In(pin[1]), .RX_Ack(ack[1]),
        .RX_Data(d1), .RX_Done_Sig(done[1]), .Parity_Err(perr[1]), .Frame_Err(ferr[1]),
        .Overrun_Err(ovr[1]), .Busy(busy[1]));
    uart_rx_param_module #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) u2 (
        .CLK(CLK), .Rst(Rst), .RX_En_Sig(en[2]), .RX_Pin_In(pin[2]), .RX_Ack(ack[2]),
        .RX_Data(d2), .RX_Done_Sig(done[2]), .Parity_Err(perr[2]), .Frame_Err(ferr[2]),
        .Overrun_Err(ovr[2]), .Busy(busy[2]));
    uart_rx_param_module #(.DATA_BITS(5), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u3 (
        .CLK(CLK), .Rst(Rst), .RX_En_Sig(en[3]), .RX_Pin_In(pin[3]), .RX_Ack(ack[3]),
        .RX_Data(d3), .RX_Done_Sig(done[3]), .Parity_Err(perr[3]), .Frame_Err(ferr[3]),
        .Overrun_Err(ovr[3]), .Busy(busy[3]));

    function automatic int nbits(input int i);
        case (i)
            1:       return 9;
            3:       return 5;
            default: return 8;
        endcase
    endfunction

    // 0 none, 1 odd, 2 even
    function automatic int pmode(input int i);
        case (i)
            1:       return 2;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int nstop(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] dout(input int i);
        case (i)
            0:       return 9'(d0);
            1:       return d1;
            2:       return 9'(d2);
            default: return 9'(d3);
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive one frame; the model decides up front whether it will be accepted
    task automatic send_frame(input int i, input logic [8:0] d, input bit bad_par,
                              input logic [1:0] stop_bad, input bit ack_dlv);
        int         nb;
        int         last_bit;
        logic       x;
        logic       pbit;
        exp_t       e;
        nb = nbits(i);
        x  = 1'b0;
        for (int k = 0; k < nb; k++) x ^= d[k];
        pbit = (pmode(i) == 2) ? x : ~x;
        if (bad_par) pbit = ~pbit;
        last_bit = nb + ((pmode(i) != 0) ? 1 : 0) + nstop(i);
        e.data = d;
        e.perr = (pmode(i) != 0) && bad_par;
        e.ferr = (stop_bad != 2'b00);
        e.mid  = cyc + CPB * last_bit + CPB / 2;
        if (!m_done[i] || ack_dlv) begin
            sb_q[i].push_back(e);
            m_done[i] = 1'b1;
            m_data[i] = e.data;
            m_perr[i] = e.perr;
            m_ferr[i] = e.ferr;
            m_ovr[i]  = 1'b0;
        end else begin
            m_ovr[i] = 1'b1;
        end
        pin[i] = 1'b0;
        tick(CPB);
        for (int k = 0; k < nb; k++) begin
            pin[i] = d[k];
            tick(CPB);
        end
        if (pmode(i) != 0) begin
            pin[i] = pbit;
            tick(CPB);
        end
        for (int s = 0; s < nstop(i); s++) begin
            pin[i] = ~stop_bad[s];
            if (s == nstop(i) - 1 && ack_dlv) begin
                // ack lands on the edge that delivers the word
                tick(CPB / 2 + 4);
                ack[i] = 1'b1;
                tick(1);
                ack[i] = 1'b0;
                tick(CPB / 2 - 5);
            end else begin
                tick(CPB);
            end
        end
        pin[i] = 1'b1;
    endtask

    task automatic do_ack(input int i, input string tag);
        ack[i] = 1'b1;
        tick(1);
        ack[i] = 1'b0;
        m_done[i] = 1'b0;
        m_perr[i] = 1'b0;
        m_ferr[i] = 1'b0;
        m_ovr[i]  = 1'b0;
        @(negedge CLK);
        chk($sformatf("%s_ack_done", tag), int'(done[i]), 0);
        chk($sformatf("%s_ack_flags", tag), int'({perr[i], ferr[i], ovr[i]}), 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input int i, input string tag);
        @(negedge CLK);
        chk($sformatf("%s_data", tag), int'(dout(i)), int'(m_data[i]));
        chk($sformatf("%s_done", tag), int'(done[i]), int'(m_done[i]));
        chk($sformatf("%s_perr", tag), int'(perr[i]), int'(m_perr[i]));
        chk($sformatf("%s_ferr", tag), int'(ferr[i]), int'(m_ferr[i]));
        chk($sformatf("%s_ovr", tag), int'(ovr[i]), int'(m_ovr[i]));
        chk($sformatf("%s_busy", tag), int'(busy[i]), 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_data[i] = '0;
            m_done[i] = 1'b0;
            m_perr[i] = 1'b0;
            m_ferr[i] = 1'b0;
            m_ovr[i]  = 1'b0;
        end
    endtask

    // Monitor: a delivery is Done rising, or Done held across an acked edge
    logic [NI-1:0] pd = '0;
    logic [NI-1:0] pa = '0;
    always @(negedge CLK) begin
        for (int i = 0; i < NI; i++) begin
            if (Rst) begin
                pd[i] = 1'b0;
                pa[i] = 1'b0;
            end else begin
                if (done[i] && (!pd[i] || pa[i])) begin
                    chk($sformatf("u%0d_dlv_expected", i), int'(sb_q[i].size() != 0), 1);
                    if (sb_q[i].size() != 0) begin
                        exp_t e;
                        int   off;
                        e = sb_q[i].pop_front();
                        chk($sformatf("u%0d_mon_data", i), int'(dout(i)), int'(e.data));
                        chk($sformatf("u%0d_mon_perr", i), int'(perr[i]), int'(e.perr));
                        chk($sformatf("u%0d_mon_ferr", i), int'(ferr[i]), int'(e.ferr));
                        chk($sformatf("u%0d_mon_ovr", i), int'(ovr[i]), 0);
                        // 2 sync + edge-detect flop, vote decided at H+1 then registered
                        off = cyc - e.mid;
                        checks++;
                        if (off < 4 || off > 6) begin
                            errors++;
                            $display("FAIL u%0d_latency: got %0d edges after mid-stop, required 4..6", i, off);
                        end
                    end
                end
                pd[i] = done[i];
                pa[i] = ack[i];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int held;
        Rst = 1'b1;
        pin = '1;
        ack = '0;
        en  = '1;
        model_reset();
        tick(3);
        for (int i = 0; i < NI; i++)
            chk($sformatf("u%0d_reset_outputs", i),
                int'({dout(i), done[i], perr[i], ferr[i], ovr[i], busy[i]}), 0);
        Rst = 1'b0;
        tick(5);

        // 1: 8N1 0xA5, hold without ack, then ack
        send_frame(0, 9'h0A5, 1'b0, 2'b00, 1'b0);
        check_state(0, "t1");
        held = 0;
        repeat (50) begin
            @(negedge CLK);
            held += int'(done[0]);
        end
        chk("t1_hold50", held, 50);
        @(posedge CLK);
        #1;
        do_ack(0, "t1");

        // 2: 9 bits even parity, good then bad
        send_frame(1, 9'h1A5, 1'b0, 2'b00, 1'b0);
        check_state(1, "t2a");
        do_ack(1, "t2a");
        send_frame(1, 9'h037, 1'b1, 2'b00, 1'b0);
        check_state(1, "t2b");
        do_ack(1, "t2b");

        // 3: two stop bits, second one low
        send_frame(2, 9'h055, 1'b0, 2'b10, 1'b0);
        tick(2);
        check_state(2, "t3");
        do_ack(2, "t3");

        // 4: 3-cycle glitch is a false start
        f = cyc;
        pin[0] = 1'b0;
        tick(3);
        pin[0] = 1'b1;
        tick(3);
        @(negedge CLK);
        chk("t4_busy_started", int'(busy[0]), 1);
        @(posedge CLK);
        #1;
        tick(f + 14 - cyc);
        @(negedge CLK);
        chk("t4_busy_cleared", int'(busy[0]), 0);
        @(posedge CLK);
        #1;
        tick(40);
        check_state(0, "t4");

        // 5: back-to-back overrun, then delivery coinciding with ack
        send_frame(0, 9'h011, 1'b0, 2'b00, 1'b0);
        send_frame(0, 9'h022, 1'b0, 2'b00, 1'b0);
        check_state(0, "t5_ovr");
        send_frame(0, 9'h033, 1'b0, 2'b00, 1'b1);
        check_state(0, "t5_ack_dlv");

        // 6a: async reset mid-frame
        pin[0] = 1'b0;
        tick(CPB * 4 + 5);
        #2;
        Rst = 1'b1;
        #1;
        chk("t6_rst_async", int'({dout(0), done[0], perr[0], ferr[0], ovr[0], busy[0]}), 0);
        model_reset();
        pin[0] = 1'b1;
        tick(3);
        Rst = 1'b0;
        tick(40);
        send_frame(0, 9'h03C, 1'b0, 2'b00, 1'b0);
        check_state(0, "t6_after_rst");
        do_ack(0, "t6a");

        // 6b: one-cycle enable drop mid-frame
        pin[0] = 1'b0;
        tick(CPB * 5 + 3);
        en[0]  = 1'b0;
        pin[0] = 1'b1;
        @(posedge CLK);
        #1;
        en[0] = 1'b1;
        @(negedge CLK);
        chk("t6_en_busy", int'(busy[0]), 0);
        chk("t6_en_data_kept", int'(dout(0)), int'(m_data[0]));
        @(posedge CLK);
        #1;
        tick(40);
        check_state(0, "t6_en_idle");
        send_frame(0, 9'h03C, 1'b0, 2'b00, 1'b0);
        check_state(0, "t6_after_en");
        do_ack(0, "t6b");

        // Randomised frames on every format
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 12; n++) begin
                logic [8:0] d;
                logic [1:0] sbm;
                bit         bp;
                bit         ad;
                int         gap;
                d   = 9'($urandom) & 9'((1 << nbits(i)) - 1);
                bp  = (pmode(i) != 0) && ($urandom_range(0, 3) == 0);
                sbm = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, (1 << nstop(i)) - 1)) : 2'b00;
                ad  = ($urandom_range(0, 3) == 0);
                send_frame(i, d, bp, sbm, ad);
                gap = $urandom_range(2, 8);
                tick(gap);
                check_state(i, $sformatf("rnd_u%0d_%0d", i, n));
                if ($urandom_range(0, 2) != 0 && m_done[i]) do_ack(i, $sformatf("rnd_u%0d_%0d", i, n));
            end
        end

        tick(10);
        for (int i = 0; i < NI; i++)
            chk($sformatf("u%0d_sb_empty", i), sb_q[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
